// File: rtl/traffic_phase_fsm.sv
// Intersection phase sequencer GREEN -> YELLOW -> RED with a 1 Hz prescaler
// and a pedestrian request that can cut GREEN short once minimum green elapses.
module traffic_phase_fsm #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GREEN_S     = 10,
  parameter int YELLOW_S    = 3,
  parameter int RED_S       = 8,
  parameter int MIN_GREEN_S = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       PED_REQ,
  output logic [2:0] state,
  output logic [2:0] LIGHT,
  output logic [7:0] sec_left,
  output logic       tick_1hz
);

  // state | meaning
  // GREEN  | through traffic, counts GREEN_S ticks or shortened by ped request
  // YELLOW | clearance, counts YELLOW_S ticks
  // RED    | stop / walk, counts RED_S ticks, discards ped requests

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [7:0] GREEN_LD  = 8'(GREEN_S - 1);
  localparam logic [7:0] YELLOW_LD = 8'(YELLOW_S - 1);
  localparam logic [7:0] RED_LD    = 8'(RED_S - 1);
  localparam logic [7:0] PED_OK    = 8'(GREEN_S - MIN_GREEN_S);

  generate
    if (CLK_HZ < 1 || GREEN_S > 255 || GREEN_S < MIN_GREEN_S || MIN_GREEN_S < 1 ||
        YELLOW_S < 1 || YELLOW_S > 255 || RED_S < 1 || RED_S > 255) begin : g_bad_params
      $error("traffic_phase_fsm: illegal duration parameters");
    end
  endgenerate

  typedef enum logic [2:0] {
    GREEN  = 3'b000,
    YELLOW = 3'b011,
    RED    = 3'b010
  } phase_t;

  phase_t        phase;
  logic [PW-1:0] pre_cnt;
  logic          ped_q;
  logic          ped_pending;
  logic          ped_edge;

  assign state    = phase;
  assign ped_edge = PED_REQ & ~ped_q;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pre_cnt  <= '0;
      tick_1hz <= 1'b0;
    end else begin
      tick_1hz <= (pre_cnt == PRE_LAST);
      pre_cnt  <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      phase       <= GREEN;
      LIGHT       <= 3'b001;
      sec_left    <= GREEN_LD;
      ped_q       <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      ped_q <= PED_REQ;
      if (ped_edge && phase != RED)
        ped_pending <= 1'b1;

      case (phase)
        GREEN: begin
          if (tick_1hz) begin
            if (sec_left == 8'd0 || (ped_pending && sec_left <= PED_OK)) begin
              phase    <= YELLOW;
              LIGHT    <= 3'b010;
              sec_left <= YELLOW_LD;
            end else begin
              sec_left <= sec_left - 8'd1;
            end
          end
        end
        YELLOW: begin
          if (tick_1hz) begin
            if (sec_left == 8'd0) begin
              phase       <= RED;
              LIGHT       <= 3'b100;
              sec_left    <= RED_LD;
              // Overrides any set above: an edge on the RED-entry cycle is dropped.
              ped_pending <= 1'b0;
            end else begin
              sec_left <= sec_left - 8'd1;
            end
          end
        end
        RED: begin
          if (tick_1hz) begin
            if (sec_left == 8'd0) begin
              phase    <= GREEN;
              LIGHT    <= 3'b001;
              sec_left <= GREEN_LD;
            end else begin
              sec_left <= sec_left - 8'd1;
            end
          end
        end
        default: begin
          phase       <= GREEN;
          LIGHT       <= 3'b001;
          sec_left    <= GREEN_LD;
          ped_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule
